// File: rtl/cache_pkg.sv
// Shared cache-line geometry and write-back FSM state encoding,
// common to the line serializer and deserializer.
package cache_pkg;

    localparam int CACHE_LINE_WORDS = 8;
    localparam int CACHE_WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } line_state_e;

endpackage

// File: rtl/line_serializer.sv
// Captures one dirty cache line and replays it to memory as LINE_WORDS
// single-word write beats on a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | line_ready high, waiting for a line from the cache
// ST_SEND | presenting beat r_cnt to memory, holds through stalls
// ST_DONE | one-cycle done pulse, then back to ST_IDLE
module line_serializer
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int WORD_W     = CACHE_WORD_W,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         line_valid,
    output logic                         line_ready,
    input  logic [LINE_WORDS*WORD_W-1:0] line_data,
    input  logic [ADDR_W-1:0]            line_addr,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W = $clog2(LINE_WORDS * WORD_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    line_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [WORD_W-1:0] r_words [LINE_WORDS];

    logic w_accept;
    logic w_beat;
    logic w_last;

    assign w_accept = line_valid && (r_state == ST_IDLE);
    assign w_beat   = (r_state == ST_SEND) && mem_ready;
    assign w_last   = (r_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SEND;
                        r_cnt   <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_beat) begin
                        if (w_last) r_state <= ST_DONE;
                        else        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Payload registers need no reset; they are only observed in ST_SEND.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_base <= line_addr & ALIGN_MASK;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= line_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign line_ready = (r_state == ST_IDLE);
    assign mem_valid  = (r_state == ST_SEND);
    assign done       = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign mem_wdata  = r_words[r_cnt];
    assign mem_addr   = r_base + ADDR_W'(r_cnt) * ADDR_W'(WORD_W / 8);

endmodule

// File: tb/tb_line_serializer.sv
// Randomised bench for line_serializer: a queue-of-beats reference model
// predicts every handshake output each cycle, plus directed line scenarios.
module tb_line_serializer;

    localparam int LW = 8;
    localparam int WW = 32;
    localparam int AW = 32;

    logic            clk;
    logic            rst;
    logic            line_valid;
    logic            line_ready;
    logic [LW*WW-1:0] line_data;
    logic [AW-1:0]   line_addr;
    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_wdata;
    logic            busy;
    logic            done;

    line_serializer #(.LINE_WORDS(LW), .WORD_W(WW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_addr  (line_addr),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a line becomes LW pending beats; done follows the last pop.
    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } beat_t;

    beat_t q[$];
    bit    m_done     = 1'b0;
    bit    model_live = 1'b0;

    function automatic bit m_ready();
        return (q.size() == 0) && !m_done;
    endfunction

    always @(posedge clk) begin
        bit    acc;
        bit    pop;
        beat_t b;
        if (rst) begin
            q.delete();
            m_done     = 1'b0;
            model_live = 1'b1;
        end else begin
            acc    = m_ready() && line_valid;
            pop    = (q.size() != 0) && mem_ready;
            m_done = 1'b0;
            if (pop) begin
                b = q.pop_front();
                if (q.size() == 0) m_done = 1'b1;
            end
            if (acc) begin
                for (int i = 0; i < LW; i++) begin
                    b.addr = (line_addr & ~32'h1F) + 32'(i * (WW / 8));
                    b.data = line_data[i*WW +: WW];
                    q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("line_ready", line_ready, m_ready());
            check("busy", busy, !m_ready());
            check("mem_valid", mem_valid, q.size() != 0);
            check("done", done, m_done);
            if (q.size() != 0) begin
                check("mem_addr", mem_addr, q[0].addr);
                check("mem_wdata", mem_wdata, q[0].data);
            end
        end
    end

    function automatic logic [LW*WW-1:0] rand_line();
        logic [LW*WW-1:0] r;
        for (int i = 0; i < LW; i++) r[i*WW +: WW] = $urandom;
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!m_ready() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < budget, 1'b1);
    endtask

    // Offers one line, scripts mem_ready, optionally pokes line_valid mid-send
    // or resets after rst_at beat cycles; returns observed mem_valid/done counts.
    task automatic send_line(input logic [AW-1:0] addr, input logic [LW*WW-1:0] data,
                             input int stall_at, input int stall_len, input bit poke,
                             input int rst_at, output int vc, output int dc,
                             output logic [AW-1:0] first_addr);
        bit seen;
        bit finished;
        vc = 0; dc = 0; seen = 1'b0; finished = 1'b0; first_addr = '0;
        wait_idle(200);
        line_addr  = addr;
        line_data  = data;
        mem_ready  = 1'b1;
        line_valid = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        for (int c = 0; c < 64 && !finished; c++) begin
            mem_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (poke && c == 3) begin
                line_valid = 1'b1;
                line_data  = ~data;
                line_addr  = 32'h0000_4000;
                check("ready_in_send", line_ready, 1'b0);
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_valid", mem_valid, 1'b0);
                check("rst_mid_done", done, 1'b0);
                check("rst_mid_ready", line_ready, 1'b1);
                return;
            end
            if (mem_valid) begin
                vc++;
                if (!seen) begin
                    first_addr = mem_addr;
                    seen = 1'b1;
                end
            end
            if (done) dc++;
            if (m_done) begin
                line_valid = 1'b0;
                finished = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("send_end", finished, 1'b1);
    endtask

    logic [LW*WW-1:0] d_seq;
    logic [AW-1:0]    fa;
    int               vc, dc, dd, md;

    initial begin
        rst = 1'b1; line_valid = 1'b0; line_data = '0; line_addr = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line_ready", line_ready, 1'b1);
        check("reset_mem_valid", mem_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < LW; i++) d_seq[i*WW +: WW] = 32'h1111_1111 * (i + 1);

        send_line(32'h0000_0100, d_seq, 0, 0, 1'b0, -1, vc, dc, fa);
        check("basic_beats", vc, 8);
        check("basic_done", dc, 1);
        check("basic_first_addr", fa, 32'h0000_0100);

        send_line(32'h0000_0100, d_seq, 2, 3, 1'b0, -1, vc, dc, fa);
        check("stall_beat_cycles", vc, 11);
        check("stall_done", dc, 1);

        send_line(32'h0000_011F, d_seq, 0, 0, 1'b1, -1, vc, dc, fa);
        check("unaligned_first_addr", fa, 32'h0000_0100);
        check("unaligned_beats", vc, 8);
        check("unaligned_done", dc, 1);

        send_line(32'h0000_0100, d_seq, 0, 0, 1'b0, 4, vc, dc, fa);
        check("rst_beats_before", vc, 4);
        check("rst_no_done", dc, 0);

        send_line(32'h0000_0240, rand_line(), 0, 0, 1'b0, -1, vc, dc, fa);
        check("after_rst_beats", vc, 8);
        check("after_rst_first_addr", fa, 32'h0000_0240);

        // Back-to-back lines with line_valid held high.
        wait_idle(200);
        dd = 0; md = 0;
        mem_ready  = 1'b1;
        line_addr  = 32'h0000_1000;
        line_data  = rand_line();
        line_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done) dd++;
            if (m_done) md++;
            if (m_ready()) begin
                line_data = rand_line();
                line_addr = line_addr + 32'h20;
            end
        end
        line_valid = 1'b0;
        wait_idle(200);
        check("b2b_done_count", dd, md);
        check("b2b_enough_lines", md >= 4, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            line_valid = ($urandom_range(0, 2) == 0);
            line_data  = rand_line();
            line_addr  = $urandom;
            mem_ready  = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst = 1'b0; line_valid = 1'b0; mem_ready = 1'b1;
        wait_idle(200);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_serializer.md
LINE_SERIALIZER -- requirements
Module: line_serializer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache line.
REQ-002 SHALL have parameter WORD_W, default 32, memory word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port line_valid  input  1  cache offers a dirty line for write-back.
REQ-007 SHALL have port line_ready  output  1  block can accept a line.
REQ-008 SHALL have port line_data  input  LINE_WORDS*WORD_W  line contents; word i at bits [i*WORD_W +: WORD_W].
REQ-009 SHALL have port line_addr  input  ADDR_W  line base byte address; low log2(LINE_WORDS*WORD_W/8) bits ignored.
REQ-010 SHALL have port mem_valid  output  1  a write beat is presented to memory.
REQ-011 SHALL have port mem_ready  input  1  memory accepts the current beat.
REQ-012 SHALL have port mem_addr  output  ADDR_W  byte address of current beat.
REQ-013 SHALL have port mem_wdata  output  WORD_W  data of current beat.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  single-cycle pulse after last beat accepted.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, DONE.
REQ-017 SHALL assert line_ready only in IDLE; line accepted when line_valid && line_ready at a rising edge.
REQ-018 SHALL on acceptance capture line_data and aligned line_addr into internal registers, clear 3-bit beat counter, and enter SEND next cycle.
REQ-019 SHALL in SEND drive mem_valid=1, mem_wdata=captured word[counter], mem_addr=aligned base + counter*WORD_W/8 (word 0 first).
REQ-020 SHALL advance on mem_valid && mem_ready: counter<LINE_WORDS-1 -> counter+1; counter=LINE_WORDS-1 -> DONE.
REQ-021 SHALL hold mem_valid, mem_addr, mem_wdata stable while mem_ready is low (unbounded stall).
REQ-022 SHALL in DONE drive done=1 for exactly one cycle and return to IDLE next cycle.
REQ-023 SHALL ignore line_valid and line_data changes outside IDLE; captured data unaffected.
REQ-024 SHALL with mem_ready held high: accept at edge N, beats at cycles N+1..N+8, done at N+9, line_ready high at N+10.
REQ-025 SHALL never wrap counter past LINE_WORDS-1; exactly LINE_WORDS beats per line.
REQ-026 SHALL keep mem_valid=0 and done=0 in IDLE; mem_wdata/mem_addr don't-care when mem_valid=0.

Reset
REQ-027 SHALL on rst=1 at an edge enter IDLE, clear counter, set mem_valid=0, done=0, busy=0, line_ready=1 next cycle.
REQ-028 SHALL on reset mid-transfer abandon remaining beats without issuing done.
REQ-029 SHALL give rst priority over any simultaneous line or memory handshake.

Structure
REQ-030 SHALL take LINE_WORDS, WORD_W and the FSM state enum from shared package cache_pkg, also used by deserializer.
REQ-031 SHALL be a single module with no sub-modules; counter and word mux inline.

Verification
REQ-032 Line 0x0000_0100, words 0x11111111..0x88888888, mem_ready=1 -> 8 beats addr 0x100,0x104..0x11C data 0x11111111..0x88888888 in order, done at N+9.
REQ-033 Same line, mem_ready low 3 cycles on beat 2 -> mem_addr=0x108, mem_wdata=0x33333333 held 4 cycles, total 11 beat cycles, single done.
REQ-034 line_addr 0x0000_011F -> beats start at 0x100; line_valid high during SEND with new data -> no effect, line_ready=0.
REQ-035 rst asserted after beat 4 accepted -> mem_valid=0 next cycle, no done, line_ready=1; new line then sends full 8 beats from word 0.
REQ-036 Back-to-back lines, line_valid held high -> second accepted at IDLE cycle after done, no beat overlap or loss.
